// File: rtl/oclib_words_to_csr_mux.sv
// oclib_words_to_csr_mux
// Bridges a word request/response stream onto a set of CSR target channels.
// A request carries {write, address, wdata}; a 4-bit field of the address
// selects the target channel. One transaction is outstanding at a time. Each
// access completes on the target's ready, or times out after a fixed number
// of cycles. The block then returns {timeout, error, rdata} as a response word.

module oclib_words_to_csr_mux #(
    parameter int Channels      = 4,
    parameter int AddressWidth  = 32,
    parameter int DataWidth     = 32,
    parameter int ChannelSelLsb = 28,
    parameter int TimeoutCycles = 1023
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [AddressWidth+DataWidth:0] wordInData,
    input  logic                            wordInValid,
    output logic                            wordInReady,
    output logic [DataWidth+1:0]            wordOutData,
    output logic                            wordOutValid,
    input  logic                            wordOutReady,
    output logic [Channels-1:0]             csrRead,
    output logic [Channels-1:0]             csrWrite,
    output logic [AddressWidth-1:0]         csrAddress,
    output logic [DataWidth-1:0]            csrWdata,
    input  logic [Channels-1:0]             csrReady,
    input  logic [Channels-1:0]             csrError,
    input  logic [Channels*DataWidth-1:0]   csrRdata,
    output logic [15:0]                     timeoutCount
);

    // The counter only has to reach TimeoutCycles-1.
    localparam int CountWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic                    req_write;
    logic [AddressWidth-1:0] req_address;
    logic [DataWidth-1:0]    req_wdata;
    logic [Channels-1:0]     chan_sel;
    logic [CountWidth-1:0]   access_count;
    logic [DataWidth+1:0]    resp_data;
    logic [15:0]             timeout_total;

    logic                    in_write;
    logic [AddressWidth-1:0] in_address;
    logic [DataWidth-1:0]    in_wdata;
    logic [3:0]              in_ch;
    logic                    in_range;
    logic [Channels-1:0]     in_sel;

    logic                    hit;
    logic                    hit_error;
    logic                    expire;
    logic [DataWidth-1:0]    rdata_sel;

    // Split the request word and decode the channel field into a one-hot select.
    // The select stays zero for a channel number outside the implemented range.
    assign in_write   = wordInData[AddressWidth+DataWidth];
    assign in_address = wordInData[AddressWidth+DataWidth-1:DataWidth];
    assign in_wdata   = wordInData[DataWidth-1:0];
    assign in_ch      = in_address[ChannelSelLsb+3:ChannelSelLsb];
    assign in_range   = ({1'b0, in_ch} < 5'(Channels));
    assign in_sel     = in_range ? (Channels'(1) << in_ch) : '0;

    // Only the selected channel's ready and error are ever looked at, so
    // other channels cannot disturb the transaction.
    assign hit       = |(csrReady & chan_sel);
    assign hit_error = |(csrError & chan_sel);
    assign expire    = (TimeoutCycles > 0) && !hit &&
                       (access_count == CountWidth'(TimeoutCycles - 1));

    // Pick the selected channel's read data lane.
    always_comb begin
        rdata_sel = '0;
        for (int k = 0; k < Channels; k++) begin
            if (chan_sel[k]) begin
                rdata_sel = csrRdata[k*DataWidth +: DataWidth];
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision. Completion takes priority over timeout expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wordInValid) begin
                    state_next = in_range ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (hit || expire) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (wordOutReady) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, access cycle counter, response word and timeout statistics.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_write     <= 1'b0;
            req_address   <= '0;
            req_wdata     <= '0;
            chan_sel      <= '0;
            access_count  <= '0;
            resp_data     <= '0;
            timeout_total <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wordInValid) begin
                        req_write    <= in_write;
                        req_address  <= in_address;
                        req_wdata    <= in_wdata;
                        chan_sel     <= in_sel;
                        access_count <= '0;
                        if (!in_range) begin
                            resp_data <= {1'b0, 1'b1, {DataWidth{1'b0}}};
                        end
                    end
                end
                ACCESS: begin
                    access_count <= access_count + 1'b1;
                    if (hit) begin
                        resp_data <= {1'b0, hit_error,
                                      req_write ? {DataWidth{1'b0}} : rdata_sel};
                    end else if (expire) begin
                        resp_data <= {1'b1, 1'b1, {DataWidth{1'b0}}};
                        if (timeout_total != 16'hFFFF) begin
                            timeout_total <= timeout_total + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and strobe outputs follow the state directly. The strobes are
    // one-hot because chan_sel is one-hot and only one direction is active.
    assign wordInReady  = (state == IDLE) && !reset;
    assign wordOutValid = (state == RESP);
    assign wordOutData  = resp_data;
    assign csrRead      = ((state == ACCESS) && !req_write) ? chan_sel : '0;
    assign csrWrite     = ((state == ACCESS) &&  req_write) ? chan_sel : '0;
    assign csrAddress   = req_address;
    assign csrWdata     = req_wdata;
    assign timeoutCount = timeout_total;

endmodule

// File: tb/tb_oclib_words_to_csr_mux.sv
// Testbench for oclib_words_to_csr_mux: table of directed transactions plus
// hand-written sequences for back-to-back operation and reset mid-access.

module tb_oclib_words_to_csr_mux;

    localparam int Channels = 4;
    localparam int Aw       = 32;
    localparam int Dw       = 32;

    logic                   clock = 1'b0;
    logic                   reset;
    logic [Aw+Dw:0]         wordInData;
    logic                   wordInValid;
    logic                   wordInReady;
    logic [Dw+1:0]          wordOutData;
    logic                   wordOutValid;
    logic                   wordOutReady;
    logic [Channels-1:0]    csrRead;
    logic [Channels-1:0]    csrWrite;
    logic [Aw-1:0]          csrAddress;
    logic [Dw-1:0]          csrWdata;
    logic [Channels-1:0]    csrReady;
    logic [Channels-1:0]    csrError;
    logic [Channels*Dw-1:0] csrRdata;
    logic [15:0]            timeoutCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ready_cycle;
        logic [31:0] rdata;
        logic        err;
        int          hold;
        logic [3:0]  exp_strobe;
        int          exp_cycles;
        logic [33:0] exp_resp;
        int          exp_tc;
    } vec_t;

    vec_t vecs[9];

    oclib_words_to_csr_mux #(
        .Channels      (Channels),
        .AddressWidth  (Aw),
        .DataWidth     (Dw),
        .ChannelSelLsb (28),
        .TimeoutCycles (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wordInData   (wordInData),
        .wordInValid  (wordInValid),
        .wordInReady  (wordInReady),
        .wordOutData  (wordOutData),
        .wordOutValid (wordOutValid),
        .wordOutReady (wordOutReady),
        .csrRead      (csrRead),
        .csrWrite     (csrWrite),
        .csrAddress   (csrAddress),
        .csrWdata     (csrWdata),
        .csrReady     (csrReady),
        .csrError     (csrError),
        .csrRdata     (csrRdata),
        .timeoutCount (timeoutCount)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=expired required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Run one transaction from the table: request, strobe phase with noise on
    // the other channels, then the response phase with an optional hold.
    task automatic applyStimulus(input vec_t v);
        int cnt;
        @(negedge clock);
        for (int k = 0; k < Channels; k++) begin
            csrRdata[k*Dw +: Dw] = v.exp_strobe[k] ? v.rdata : (32'hF0F0_0000 | k);
        end
        wordInData  = {v.wr, v.addr, v.wdata};
        wordInValid = 1'b1;
        checkOutput("accept ready", wordInReady, 1);
        @(negedge clock);
        wordInValid = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (csrRead == '0 && csrWrite == '0) break;
            cnt++;
            checkOutput("strobe", v.wr ? csrWrite : csrRead, v.exp_strobe);
            checkOutput("other strobe", v.wr ? csrRead : csrWrite, 0);
            checkOutput("csrAddress", csrAddress, v.addr);
            checkOutput("csrWdata", csrWdata, v.wdata);
            checkOutput("ready in access", wordInReady, 0);
            if (cnt == v.ready_cycle) begin
                csrReady = 4'hF;
                csrError = v.err ? 4'hF : ~v.exp_strobe;
            end else begin
                csrReady = ~v.exp_strobe;
                csrError = ~v.exp_strobe;
            end
            @(negedge clock);
        end
        csrReady = '0;
        csrError = '0;
        checkOutput("strobe cycles", cnt, v.exp_cycles);
        checkOutput("resp valid", wordOutValid, 1);
        checkOutput("resp data", wordOutData, v.exp_resp);
        checkOutput("timeoutCount", timeoutCount, v.exp_tc);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clock);
            checkOutput("hold data", wordOutData, v.exp_resp);
            checkOutput("hold valid", wordOutValid, 1);
            checkOutput("hold in ready", wordInReady, 0);
        end
        wordOutReady = 1'b1;
        @(negedge clock);
        wordOutReady = 1'b0;
        checkOutput("after resp valid", wordOutValid, 0);
        checkOutput("after resp in ready", wordInReady, 1);
    endtask

    initial begin
        //           wr    addr          wdata        rdy rdata        err hold strobe cyc resp                 tc
        vecs[0] = '{1'b0, 32'h1000_0010, 32'h0,       3, 32'hDEAD_BEEF, 1'b0, 0, 4'b0010, 3, 34'h0_DEAD_BEEF, 0};
        vecs[1] = '{1'b1, 32'h3000_0004, 32'h55AA,    1, 32'h1234_5678, 1'b1, 0, 4'b1000, 1, 34'h1_0000_0000, 0};
        vecs[2] = '{1'b0, 32'h7000_0000, 32'h0,       0, 32'h0,         1'b0, 0, 4'b0000, 0, 34'h1_0000_0000, 0};
        vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,       0, 32'h9999_9999, 1'b0, 0, 4'b0001, 8, 34'h3_0000_0000, 1};
        vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,       8, 32'hCAFE_0001, 1'b0, 0, 4'b0001, 8, 34'h0_CAFE_0001, 1};
        vecs[5] = '{1'b0, 32'h2000_0100, 32'h0,       2, 32'h0BAD_F00D, 1'b0, 5, 4'b0100, 2, 34'h0_0BAD_F00D, 1};
        vecs[6] = '{1'b1, 32'h0ABC_0000, 32'h1357_9BDF,1, 32'h7777_7777, 1'b0, 0, 4'b0001, 1, 34'h0_0000_0000, 1};
        vecs[7] = '{1'b0, 32'h3000_0FFC, 32'h0,       5, 32'hA5A5_A5A5, 1'b1, 0, 4'b1000, 5, 34'h1_A5A5_A5A5, 1};
        vecs[8] = '{1'b1, 32'h2000_0040, 32'hFFFF,    0, 32'h0,         1'b0, 0, 4'b0100, 8, 34'h3_0000_0000, 2};

        reset        = 1'b1;
        wordInData   = '0;
        wordInValid  = 1'b0;
        wordOutReady = 1'b0;
        csrReady     = '0;
        csrError     = '0;
        csrRdata     = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset in ready", wordInReady, 1);
        checkOutput("reset out valid", wordOutValid, 0);
        checkOutput("reset strobes", {csrRead, csrWrite}, 0);
        checkOutput("reset out data", wordOutData, 0);
        checkOutput("reset address", csrAddress, 0);
        checkOutput("reset wdata", csrWdata, 0);
        checkOutput("reset timeoutCount", timeoutCount, 0);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        // Back-to-back at minimum latency with the response side always ready.
        @(negedge clock);
        csrRdata[1*Dw +: Dw] = 32'h1111_2222;
        csrReady     = 4'b0010;
        wordOutReady = 1'b1;
        wordInData   = {1'b0, 32'h1000_0000, 32'h0};
        wordInValid  = 1'b1;
        checkOutput("b2b accept", wordInReady, 1);
        @(negedge clock);
        checkOutput("b2b strobe N+1", csrRead, 4'b0010);
        @(negedge clock);
        checkOutput("b2b valid N+2", wordOutValid, 1);
        checkOutput("b2b data N+2", wordOutData, 34'h0_1111_2222);
        checkOutput("b2b in ready N+2", wordInReady, 0);
        @(negedge clock);
        checkOutput("b2b in ready N+3", wordInReady, 1);
        @(negedge clock);
        wordInValid = 1'b0;
        checkOutput("b2b strobe N+4", csrRead, 4'b0010);
        @(negedge clock);
        checkOutput("b2b second valid", wordOutValid, 1);
        @(negedge clock);
        checkOutput("b2b idle valid", wordOutValid, 0);
        csrReady     = '0;
        wordOutReady = 1'b0;

        // Reset pulsed in the middle of an access on channel 2.
        @(negedge clock);
        wordInData  = {1'b0, 32'h2000_0008, 32'h0};
        wordInValid = 1'b1;
        @(negedge clock);
        wordInValid = 1'b0;
        checkOutput("rst pre strobe", csrRead, 4'b0100);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst strobes", {csrRead, csrWrite}, 0);
        checkOutput("rst out valid", wordOutValid, 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("post rst out valid", wordOutValid, 0);
        checkOutput("post rst in ready", wordInReady, 1);
        checkOutput("post rst timeoutCount", timeoutCount, 0);
        checkOutput("post rst address", csrAddress, 0);
        applyStimulus(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
